// File: rtl/kbd_matrix_ctrl_if.sv
// Host-side bundle for the keyboard matrix controller: PS/2 event input, keymap ROM port,
// matrix readout port and status flags.
interface kbd_matrix_ctrl_if #(
    parameter int COLS  = 8,
    parameter int MAP_W = 1
);
    logic               ps2_stb;
    logic [9:0]         ps2_code;
    logic [MAP_W-1:0]   map_sel;
    logic [MAP_W+8:0]   map_addr;
    logic [7:0]         map_data;
    logic [3:0]         row_sel;
    logic [COLS-1:0]    col_n;
    logic               all_up;
    logic               busy;
    logic               fifo_ovf;

    modport master (
        output ps2_stb, ps2_code, map_sel, map_data, row_sel, all_up,
        input  map_addr, col_n, busy, fifo_ovf
    );

    modport slave (
        input  ps2_stb, ps2_code, map_sel, map_data, row_sel, all_up,
        output map_addr, col_n, busy, fifo_ovf
    );
endinterface

// File: rtl/kbd_matrix_ctrl.sv
// PS/2 event to key-matrix translator: buffers scancode events, looks each one up in a keymap
// ROM and sets/clears the mapped matrix bit; the host reads one active-low row at a time.
module kbd_matrix_ctrl #(
    parameter int ROWS       = 11,
    parameter int COLS       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAP_W      = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clk_ena,
    kbd_matrix_ctrl_if.slave   bus
);
    localparam int         PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [4:0] ROWS_L = 5'(ROWS);
    localparam logic [3:0] COLS_L = 4'(COLS);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT, S_APPLY} state_t;

    state_t             state_q, state_d;
    logic [9:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full, pop, push;
    logic [9:0]         head;
    logic               brk_q;
    logic [7:0]         rom_q;
    logic [MAP_W+8:0]   map_addr_q;
    logic [COLS-1:0]    col_n_q;
    logic               ovf_q;
    logic [COLS-1:0]    matrix [ROWS];
    logic               apply_wr;
    logic               row_sel_ok;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
    // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
    assign push       = bus.ps2_stb && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        if (clk_ena) begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_LOOKUP;
                    end
                end
                S_LOOKUP: state_d = S_WAIT;
                S_WAIT:   state_d = S_APPLY;
                S_APPLY:  state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: the event storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= bus.ps2_code;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (bus.ps2_stb && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

    // map_sel is captured at pop time, so a later layout change cannot touch this event.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            brk_q      <= 1'b0;
            map_addr_q <= '0;
            rom_q      <= '0;
        end else begin
            if (pop) begin
                brk_q      <= head[9];
                map_addr_q <= {bus.map_sel, head[8:0]};
            end
            if (clk_ena && state_q == S_WAIT) rom_q <= bus.map_data;
        end
    end

    assign apply_wr = clk_ena && (state_q == S_APPLY) && rom_q[7] &&
                      ({1'b0, rom_q[3:0]} < ROWS_L) && ({1'b0, rom_q[6:4]} < COLS_L);

    always_ff @(posedge clk) begin
        if (!reset_n || bus.all_up) begin
            for (int r = 0; r < ROWS; r++) matrix[r] <= '0;
        end else if (apply_wr) begin
            matrix[rom_q[3:0]][rom_q[6:4]] <= !brk_q;
        end
    end

    assign row_sel_ok = ({1'b0, bus.row_sel} < ROWS_L);

    always_ff @(posedge clk) begin
        if (!reset_n)     col_n_q <= '1;
        else if (clk_ena) col_n_q <= row_sel_ok ? ~matrix[bus.row_sel] : '1;
    end

    assign bus.map_addr = map_addr_q;
    assign bus.col_n    = col_n_q;
    assign bus.fifo_ovf = ovf_q;
    assign bus.busy     = (state_q != S_IDLE) || !fifo_empty;
endmodule
